// File: rtl/adc_dc_pkg.sv
// Shared types and helpers for the ADC DC conditioner.
package adc_dc_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned CLAMP_W = 64;
    localparam int unsigned CLIP_W  = 16;

    function automatic int unsigned decim_log2(input int unsigned decim);
        return $clog2(decim);
    endfunction

    // Saturate a wide signed value into the signed range of out_w bits.
    function automatic logic signed [CLAMP_W-1:0] sat_clamp(
        input logic signed [CLAMP_W-1:0] value,
        input int unsigned               out_w
    );
        logic signed [CLAMP_W-1:0] max_v;
        logic signed [CLAMP_W-1:0] min_v;
        max_v = $signed((CLAMP_W'(1) << (out_w - 1)) - CLAMP_W'(1));
        min_v = ~max_v;
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/decim_accum.sv
// Block-averaging decimator: sums DECIM valid codes and emits their mean.
module decim_accum
    import adc_dc_pkg::*;
#(
    parameter int unsigned ADC_W = 12,
    parameter int unsigned DECIM = 4
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             adc_valid_in,
    input  logic [ADC_W-1:0] adc_data_in,
    output logic [ADC_W-1:0] avg,
    output logic             avg_vld
);

    localparam int unsigned LOG2  = decim_log2(DECIM);
    localparam int unsigned ACC_W = ADC_W + LOG2;
    localparam int unsigned CNT_W = (LOG2 > 0) ? LOG2 : 1;

    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum_c;

    assign sum_c = acc + ACC_W'(adc_data_in);

    // The group-closing sample is folded into the average directly; acc restarts the same cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt     <= '0;
            acc     <= '0;
            avg     <= '0;
            avg_vld <= 1'b0;
        end else begin
            avg_vld <= 1'b0;
            if (adc_valid_in) begin
                if (cnt == CNT_W'(DECIM - 1)) begin
                    avg     <= ADC_W'(sum_c >> LOG2);
                    avg_vld <= 1'b1;
                    acc     <= '0;
                    cnt     <= '0;
                end else begin
                    acc <= sum_c;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/adc_dc_conditioner.sv
// Decimate raw ADC codes, remove tracked DC with a leaky integrator, scale and saturate.
// Optional raw-code clip counter enabled by defining ADC_CLIP_CNT_EN.
module adc_dc_conditioner
    import adc_dc_pkg::*;
#(
    parameter int unsigned ADC_W       = 12,
    parameter int unsigned OUT_W       = 16,
    parameter int unsigned DECIM       = 4,
    parameter int unsigned ALPHA_SHIFT = 10,
    parameter int unsigned GAIN_SHIFT  = 2
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    adc_valid_in,
    input  logic [ADC_W-1:0]        adc_data_in,
    input  logic                    hold_dc_in,
    output logic                    ready_out,
    output logic signed [OUT_W-1:0] x_out,
    output logic [ADC_W-1:0]        dc_out,
    output logic                    sat_out,
    output logic [CLIP_W-1:0]       clip_cnt_out
);

    localparam int unsigned DC_W   = ADC_W + ALPHA_SHIFT + 1;
    localparam int unsigned DIFF_W = ADC_W + 1;

    logic [ADC_W-1:0]         avg;
    logic                     avg_vld;
    state_t                   state;
    state_t                   state_nxt;
    logic [DC_W-1:0]          dc_acc;
    logic [DC_W-1:0]          dc_acc_nxt;
    logic [ADC_W-1:0]         dc_est;
    logic signed [DIFF_W-1:0] diff_nxt;
    logic signed [DIFF_W-1:0] diff_q;
    logic                     b_vld;
    logic signed [CLAMP_W-1:0] scaled_c;
    logic signed [CLAMP_W-1:0] clamped_c;

    decim_accum #(
        .ADC_W (ADC_W),
        .DECIM (DECIM)
    ) u_decim_accum (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .adc_valid_in (adc_valid_in),
        .adc_data_in  (adc_data_in),
        .avg          (avg),
        .avg_vld      (avg_vld)
    );

    assign dc_est = ADC_W'(dc_acc >> ALPHA_SHIFT);
    assign dc_out = dc_est;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // First average preloads the tracker; later ones subtract and leak it toward the input.
    always_comb begin
        state_nxt  = state;
        dc_acc_nxt = dc_acc;
        diff_nxt   = '0;
        if (avg_vld) begin
            case (state)
                INIT: begin
                    dc_acc_nxt = DC_W'(avg) << ALPHA_SHIFT;
                    state_nxt  = RUN;
                end
                RUN: begin
                    diff_nxt = $signed({1'b0, avg}) - $signed({1'b0, dc_est});
                    if (!hold_dc_in) begin
                        dc_acc_nxt = dc_acc + DC_W'(avg) - (dc_acc >> ALPHA_SHIFT);
                    end
                end
                default: state_nxt = INIT;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            dc_acc <= '0;
            diff_q <= '0;
            b_vld  <= 1'b0;
        end else begin
            dc_acc <= dc_acc_nxt;
            b_vld  <= avg_vld;
            if (avg_vld) begin
                diff_q <= diff_nxt;
            end
        end
    end

    assign scaled_c  = CLAMP_W'(diff_q) <<< GAIN_SHIFT;
    assign clamped_c = sat_clamp(scaled_c, OUT_W);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ready_out <= 1'b0;
            sat_out   <= 1'b0;
            x_out     <= '0;
        end else begin
            ready_out <= b_vld;
            sat_out   <= b_vld && (clamped_c != scaled_c);
            if (b_vld) begin
                x_out <= OUT_W'(clamped_c);
            end
        end
    end

`ifdef ADC_CLIP_CNT_EN
    // Counts rail codes on the raw input; sticks at full scale.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            clip_cnt_out <= '0;
        end else if (adc_valid_in
                     && ((adc_data_in == '0) || (adc_data_in == {ADC_W{1'b1}}))
                     && (clip_cnt_out != {CLIP_W{1'b1}})) begin
            clip_cnt_out <= clip_cnt_out + CLIP_W'(1);
        end
    end
`else
    assign clip_cnt_out = '0;
`endif

endmodule

// File: tb/tb_adc_dc_conditioner.sv
// Directed bench for adc_dc_conditioner: default gain instance plus a GAIN_SHIFT=5 instance on shared stimulus.
module tb_adc_dc_conditioner;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        adc_valid_in;
    logic [11:0] adc_data_in;
    logic        hold_dc_in;

    logic               ready_out, sat_out;
    logic signed [15:0] x_out;
    logic [11:0]        dc_out;
    logic [15:0]        clip_cnt_out;

    logic               ready5, sat5;
    logic signed [15:0] x5;
    logic [11:0]        dc5;
    logic [15:0]        clip5;

    int checks = 0;
    int errors = 0;
    int rdy_cnt = 0;

    always #5 clk_in = ~clk_in;

    adc_dc_conditioner dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .adc_valid_in (adc_valid_in),
        .adc_data_in  (adc_data_in),
        .hold_dc_in   (hold_dc_in),
        .ready_out    (ready_out),
        .x_out        (x_out),
        .dc_out       (dc_out),
        .sat_out      (sat_out),
        .clip_cnt_out (clip_cnt_out)
    );

    adc_dc_conditioner #(.GAIN_SHIFT(5)) dut_g5 (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .adc_valid_in (adc_valid_in),
        .adc_data_in  (adc_data_in),
        .hold_dc_in   (hold_dc_in),
        .ready_out    (ready5),
        .x_out        (x5),
        .dc_out       (dc5),
        .sat_out      (sat5),
        .clip_cnt_out (clip5)
    );

    always @(negedge clk_in) begin
        if (ready_out) rdy_cnt = rdy_cnt + 1;
    end

    typedef struct {
        int val;
        bit hold;
        int exp_x;
        int exp_dc;
        bit exp_sat;
        int exp_x5;
        bit exp_sat5;
    } vec_t;

    vec_t ph1[5];
    vec_t ph2[17];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic send_valid(input int val);
        @(posedge clk_in); #1;
        adc_valid_in = 1'b1;
        adc_data_in  = 12'(val);
        @(posedge clk_in); #1;
        adc_valid_in = 1'b0;
        repeat (30) @(posedge clk_in);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " x_out"}, x_out, 0);
        chk({tag, " dc_out"}, dc_out, 0);
        chk({tag, " ready_out"}, ready_out, 0);
        chk({tag, " sat_out"}, sat_out, 0);
        chk({tag, " clip_cnt"}, clip_cnt_out, 0);
        chk({tag, " x_out_g5"}, x5, 0);
    endtask

    task automatic run_group(input vec_t v, input string tag);
        int lat;
        lat = 0;
        hold_dc_in = v.hold;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_in); #1;
            adc_valid_in = 1'b1;
            adc_data_in  = 12'(v.val);
            if (i < 3) begin
                @(posedge clk_in); #1;
                adc_valid_in = 1'b0;
                repeat (30) @(posedge clk_in);
            end
        end
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk_in); #1;
            if (c == 1) adc_valid_in = 1'b0;
            if (ready_out) begin
                lat = c;
                break;
            end
        end
        chk({tag, " latency"}, lat, 3);
        chk({tag, " ready_g5"}, ready5, 1);
        chk({tag, " x_out"}, x_out, v.exp_x);
        chk({tag, " dc_out"}, dc_out, v.exp_dc);
        chk({tag, " sat_out"}, sat_out, v.exp_sat);
        chk({tag, " x_out_g5"}, x5, v.exp_x5);
        chk({tag, " sat_g5"}, sat5, v.exp_sat5);
        @(posedge clk_in); #1;
        chk({tag, " ready pulse"}, ready_out, 0);
        chk({tag, " sat_g5 pulse"}, sat5, 0);
        repeat (40) @(posedge clk_in);
        hold_dc_in = 1'b0;
    endtask

    initial begin
        // Phase 1 from reset: hold ignored during preload, then a rail-to-rail excursion.
        ph1[0] = '{1780, 1'b1, 0,     1780, 1'b0, 0,      1'b0};
        ph1[1] = '{1780, 1'b0, 0,     1780, 1'b0, 0,      1'b0};
        ph1[2] = '{1780, 1'b0, 0,     1780, 1'b0, 0,      1'b0};
        ph1[3] = '{4095, 1'b0, 9260,  1782, 1'b0, 32767,  1'b1};
        ph1[4] = '{0,    1'b0, -7128, 1780, 1'b0, -32768, 1'b1};
        // Phase 2 after reset: preload, hold at 1880, then free tracking of the step.
        ph2[0] = '{1780, 1'b0, 0, 1780, 1'b0, 0, 1'b0};
        ph2[1] = '{1780, 1'b0, 0, 1780, 1'b0, 0, 1'b0};
        for (int i = 2; i <= 4; i++) ph2[i] = '{1880, 1'b1, 400, 1780, 1'b0, 3200, 1'b0};
        for (int i = 5; i <= 14; i++) ph2[i] = '{1880, 1'b0, 400, 1780, 1'b0, 3200, 1'b0};
        ph2[15] = '{1880, 1'b0, 400, 1781, 1'b0, 3200, 1'b0};
        ph2[16] = '{1880, 1'b0, 396, 1781, 1'b0, 3168, 1'b0};

        rst_n_in     = 1'b0;
        adc_valid_in = 1'b0;
        adc_data_in  = '0;
        hold_dc_in   = 1'b0;
        repeat (3) @(posedge clk_in); #1;
        check_zero("reset");
        rst_n_in = 1'b1;

        for (int i = 0; i < 5; i++) run_group(ph1[i], $sformatf("ph1[%0d]", i));
`ifdef ADC_CLIP_CNT_EN
        chk("ph1 clip_cnt", clip_cnt_out, 8);
`else
        chk("ph1 clip_cnt", clip_cnt_out, 0);
`endif

        // Partial group, then asynchronous reset between clock edges.
        send_valid(1780);
        send_valid(1780);
        repeat (5) @(posedge clk_in);
        #3;
        rst_n_in = 1'b0;
        #1;
        check_zero("async reset");
        @(posedge clk_in); #1;
        adc_valid_in = 1'b1;
        adc_data_in  = 12'd4095;
        @(posedge clk_in); #1;
        adc_valid_in = 1'b0;
        rdy_cnt = 0;
        rst_n_in = 1'b1;

        for (int i = 0; i < 17; i++) begin
            run_group(ph2[i], $sformatf("ph2[%0d]", i));
            if (i == 0) chk("ready count after reset", rdy_cnt, 1);
        end

        // Clip counter after a fresh reset: three rail codes, no completed group.
        rst_n_in = 1'b0;
        repeat (2) @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        rdy_cnt = 0;
        for (int i = 0; i < 3; i++) send_valid(4095);
        repeat (10) @(posedge clk_in); #1;
`ifdef ADC_CLIP_CNT_EN
        chk("clip_cnt three rails", clip_cnt_out, 3);
`else
        chk("clip_cnt three rails", clip_cnt_out, 0);
`endif
        chk("no ready on partial group", rdy_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
